// File: rtl/id_branch_stall_ctrl.sv
// rtl/id_branch_stall_ctrl.sv - ID-stage branch hazard stall/flush sequencer with stall-cycle counter
module id_branch_stall_ctrl #(
   parameter int         CNT_W      = 16,
   parameter logic [6:0] OPC_BRANCH = 7'b1100011,
   parameter logic [6:0] OPC_JALR   = 7'b1100111,
   parameter bit         EN_JALR    = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             hold,
   input  logic [6:0]       ID_opcode,
   input  logic [4:0]       ID_ReadRegNum1,
   input  logic [4:0]       ID_ReadRegNum2,
   input  logic             ID_BranchTaken,
   input  logic             EX_cntl_RegWrite,
   input  logic             EX_cntl_MemRead,
   input  logic [4:0]       EX_WriteRegNum,
   input  logic             MEM_cntl_MemRead,
   input  logic [4:0]       MEM_WriteRegNum,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             ID_EX_Bubble,
   output logic             IF_ID_Flush,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_STALL = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_rem;
   logic [CNT_W-1:0] r_stall_cycles;

   logic       w_is_br;
   logic       w_is_jr;
   logic       w_use_rs1;
   logic       w_use_rs2;
   logic       w_ex_match;
   logic       w_mem_match;
   logic       w_ex_load_dep;
   logic       w_ex_alu_dep;
   logic       w_mem_load_dep;
   logic [1:0] w_need;

   // Decode which sources the ID instruction actually reads for its compare
   assign w_is_br   = (ID_opcode == OPC_BRANCH);
   assign w_is_jr   = EN_JALR && (ID_opcode == OPC_JALR);
   assign w_use_rs1 = w_is_br | w_is_jr;
   assign w_use_rs2 = w_is_br;

   // A producer only matters if it targets a non-zero register that a used source reads
   assign w_ex_match = (EX_WriteRegNum != 5'd0) &&
                       ((w_use_rs1 && (EX_WriteRegNum == ID_ReadRegNum1)) ||
                        (w_use_rs2 && (EX_WriteRegNum == ID_ReadRegNum2)));
   assign w_mem_match = (MEM_WriteRegNum != 5'd0) &&
                        ((w_use_rs1 && (MEM_WriteRegNum == ID_ReadRegNum1)) ||
                         (w_use_rs2 && (MEM_WriteRegNum == ID_ReadRegNum2)));

   // A load in EX needs two cycles before its data reaches WB forwarding; an ALU
   // result in EX or a load in MEM needs one
   assign w_ex_load_dep  = EX_cntl_MemRead && w_ex_match;
   assign w_ex_alu_dep   = EX_cntl_RegWrite && !EX_cntl_MemRead && w_ex_match;
   assign w_mem_load_dep = MEM_cntl_MemRead && w_mem_match;
   assign w_need = w_ex_load_dep                    ? 2'd2 :
                   (w_ex_alu_dep || w_mem_load_dep) ? 2'd1 : 2'd0;

   // Pipeline control outputs: reset forces free-run, hold freezes everything, then stall, then redirect
   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;
      IF_ID_Flush  = 1'b0;
      if (!reset_n) begin
         PCWrite     = 1'b1;
         IF_ID_Write = 1'b1;
      end else if (hold) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
      end else if ((r_state == S_STALL) && r_rem) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else if ((r_state == S_IDLE) && (w_need != 2'd0)) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else begin
         IF_ID_Flush = ID_BranchTaken & (w_is_br | w_is_jr);
      end
   end

   // Stall sequencer and saturating bubble counter, both frozen while hold is asserted
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_rem          <= 1'b0;
         r_stall_cycles <= '0;
      end else if (!hold) begin
         if (ID_EX_Bubble && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (w_need == 2'd2) begin
                  r_state <= S_STALL;
                  r_rem   <= 1'b1;
               end
            end
            S_STALL: begin
               r_rem   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_rem   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_id_branch_stall_ctrl.sv
// tb/tb_id_branch_stall_ctrl.sv - directed self-checking bench for id_branch_stall_ctrl
module tb_id_branch_stall_ctrl;

   localparam logic [6:0] OPC_BEQ  = 7'b1100011;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [6:0] OPC_ALU  = 7'b0110011;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       hold;
   logic [6:0] ID_opcode;
   logic [4:0] ID_ReadRegNum1;
   logic [4:0] ID_ReadRegNum2;
   logic       ID_BranchTaken;
   logic       EX_cntl_RegWrite;
   logic       EX_cntl_MemRead;
   logic [4:0] EX_WriteRegNum;
   logic       MEM_cntl_MemRead;
   logic [4:0] MEM_WriteRegNum;

   logic        pc_write, ifid_write, bubble, flush;
   logic [15:0] stall_cnt;
   logic        nj_pc_write, nj_ifid_write, nj_bubble, nj_flush;
   logic [15:0] nj_stall_cnt;
   logic        c2_pc_write, c2_ifid_write, c2_bubble, c2_flush;
   logic [1:0]  c2_stall_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_branch_stall_ctrl u_dut (
      .clk(clk), .reset_n(reset_n), .hold(hold), .ID_opcode(ID_opcode),
      .ID_ReadRegNum1(ID_ReadRegNum1), .ID_ReadRegNum2(ID_ReadRegNum2), .ID_BranchTaken(ID_BranchTaken),
      .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_cntl_MemRead(EX_cntl_MemRead), .EX_WriteRegNum(EX_WriteRegNum),
      .MEM_cntl_MemRead(MEM_cntl_MemRead), .MEM_WriteRegNum(MEM_WriteRegNum),
      .PCWrite(pc_write), .IF_ID_Write(ifid_write), .ID_EX_Bubble(bubble), .IF_ID_Flush(flush),
      .stall_cycles(stall_cnt)
   );

   id_branch_stall_ctrl #(.EN_JALR(1'b0)) u_nojalr (
      .clk(clk), .reset_n(reset_n), .hold(hold), .ID_opcode(ID_opcode),
      .ID_ReadRegNum1(ID_ReadRegNum1), .ID_ReadRegNum2(ID_ReadRegNum2), .ID_BranchTaken(ID_BranchTaken),
      .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_cntl_MemRead(EX_cntl_MemRead), .EX_WriteRegNum(EX_WriteRegNum),
      .MEM_cntl_MemRead(MEM_cntl_MemRead), .MEM_WriteRegNum(MEM_WriteRegNum),
      .PCWrite(nj_pc_write), .IF_ID_Write(nj_ifid_write), .ID_EX_Bubble(nj_bubble), .IF_ID_Flush(nj_flush),
      .stall_cycles(nj_stall_cnt)
   );

   id_branch_stall_ctrl #(.CNT_W(2)) u_cnt2 (
      .clk(clk), .reset_n(reset_n), .hold(hold), .ID_opcode(ID_opcode),
      .ID_ReadRegNum1(ID_ReadRegNum1), .ID_ReadRegNum2(ID_ReadRegNum2), .ID_BranchTaken(ID_BranchTaken),
      .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_cntl_MemRead(EX_cntl_MemRead), .EX_WriteRegNum(EX_WriteRegNum),
      .MEM_cntl_MemRead(MEM_cntl_MemRead), .MEM_WriteRegNum(MEM_WriteRegNum),
      .PCWrite(c2_pc_write), .IF_ID_Write(c2_ifid_write), .ID_EX_Bubble(c2_bubble), .IF_ID_Flush(c2_flush),
      .stall_cycles(c2_stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2, input logic taken);
      ID_opcode = opc; ID_ReadRegNum1 = rs1; ID_ReadRegNum2 = rs2; ID_BranchTaken = taken;
   endtask

   task automatic set_ex(input logic rw, input logic mr, input logic [4:0] rd);
      EX_cntl_RegWrite = rw; EX_cntl_MemRead = mr; EX_WriteRegNum = rd;
   endtask

   task automatic set_mem(input logic mr, input logic [4:0] rd);
      MEM_cntl_MemRead = mr; MEM_WriteRegNum = rd;
   endtask

   task automatic clear_all();
      hold = 1'b0;
      set_id(7'd0, 5'd0, 5'd0, 1'b0);
      set_ex(1'b0, 1'b0, 5'd0);
      set_mem(1'b0, 5'd0);
   endtask

   task automatic do_reset();
      clear_all();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear_all();
      reset_n = 1'b0;
      set_id(OPC_BEQ, 5'd5, 5'd6, 1'b1);
      set_ex(1'b1, 1'b1, 5'd5);
      #1;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_pcwrite: got %b want 1", pc_write); end
      checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL rst_ifidwrite: got %b want 1", ifid_write); end
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b want 0", bubble); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush); end
      tick();
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", stall_cnt); end
      reset_n = 1'b1;
      clear_all();
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(OPC_BEQ, 5'd5, 5'd6, 1'b0);
      set_ex(1'b1, 1'b1, 5'd5);
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble1: got %b want 1", bubble); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pcwrite1: got %b want 0", pc_write); end
      checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifidwrite1: got %b want 0", ifid_write); end
      tick();
      set_ex(1'b0, 1'b0, 5'd0);
      set_mem(1'b1, 5'd5);
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble2: got %b want 1", bubble); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pcwrite2: got %b want 0", pc_write); end
      tick();
      set_mem(1'b0, 5'd0);
      #1;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_pcwrite3: got %b want 1", pc_write); end
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL lu_bubble3: got %b want 0", bubble); end
      checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_count: got %0d want 2", stall_cnt); end
   endtask

   task automatic test_single_stall();
      do_reset();
      set_id(OPC_BEQ, 5'd5, 5'd0, 1'b0);
      set_ex(1'b1, 1'b0, 5'd5);
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL alu_bubble: got %b want 1", bubble); end
      tick();
      set_ex(1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL alu_pcwrite: got %b want 1", pc_write); end
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL alu_bubble_after: got %b want 0", bubble); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL alu_count: got %0d want 1", stall_cnt); end
      set_id(OPC_BEQ, 5'd5, 5'd6, 1'b0);
      set_mem(1'b1, 5'd6);
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL memld_bubble: got %b want 1", bubble); end
      tick();
      set_mem(1'b0, 5'd0);
      #1;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL memld_pcwrite: got %b want 1", pc_write); end
      checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL memld_count: got %0d want 2", stall_cnt); end
   endtask

   task automatic test_rd_zero_flush();
      do_reset();
      set_id(OPC_BEQ, 5'd0, 5'd0, 1'b1);
      set_ex(1'b1, 1'b1, 5'd0);
      #1;
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL x0_bubble: got %b want 0", bubble); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL x0_flush: got %b want 1", flush); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL x0_pcwrite: got %b want 1", pc_write); end
      ID_BranchTaken = 1'b0;
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL x0_flush_nt: got %b want 0", flush); end
   endtask

   task automatic test_jalr();
      do_reset();
      set_id(OPC_JALR, 5'd7, 5'd5, 1'b1);
      set_ex(1'b1, 1'b1, 5'd7);
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL jr_bubble1: got %b want 1", bubble); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jr_flush1: got %b want 0", flush); end
      checks++; if (nj_bubble !== 1'b0) begin errors++; $display("FAIL nj_bubble: got %b want 0", nj_bubble); end
      checks++; if (nj_flush !== 1'b0) begin errors++; $display("FAIL nj_flush: got %b want 0", nj_flush); end
      checks++; if (nj_pc_write !== 1'b1) begin errors++; $display("FAIL nj_pcwrite: got %b want 1", nj_pc_write); end
      tick();
      set_ex(1'b0, 1'b0, 5'd0);
      set_mem(1'b1, 5'd7);
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL jr_bubble2: got %b want 1", bubble); end
      tick();
      set_mem(1'b0, 5'd0);
      #1;
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL jr_bubble3: got %b want 0", bubble); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jr_flush3: got %b want 1", flush); end
      checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL jr_count: got %0d want 2", stall_cnt); end
      checks++; if (nj_stall_cnt !== 16'd0) begin errors++; $display("FAIL nj_count: got %0d want 0", nj_stall_cnt); end
   endtask

   task automatic test_hold();
      do_reset();
      set_id(OPC_BEQ, 5'd5, 5'd6, 1'b0);
      set_ex(1'b1, 1'b1, 5'd5);
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL hold_bubble1: got %b want 1", bubble); end
      tick();
      hold = 1'b1;
      set_ex(1'b0, 1'b0, 5'd0);
      set_mem(1'b1, 5'd5);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({pc_write, ifid_write, bubble, flush} !== 4'b0000) begin errors++; $display("FAIL hold_outs%0d: got %b want 0000", i, {pc_write, ifid_write, bubble, flush}); end
         checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL hold_count%0d: got %0d want 1", i, stall_cnt); end
         tick();
      end
      hold = 1'b0;
      #1;
      checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL hold_resume_bubble: got %b want 1", bubble); end
      tick();
      set_mem(1'b0, 5'd0);
      #1;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL hold_pcwrite: got %b want 1", pc_write); end
      checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL hold_count: got %0d want 2", stall_cnt); end
      set_id(OPC_BEQ, 5'd0, 5'd0, 1'b1);
      hold = 1'b1;
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL hold_flush: got %b want 0", flush); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL hold_flush_pcwrite: got %b want 0", pc_write); end
      hold = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(OPC_BEQ, 5'd5, 5'd6, 1'b0);
      set_ex(1'b1, 1'b1, 5'd5);
      tick();
      clear_all();
      reset_n = 1'b0;
      #1;
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL mrst_bubble_in: got %b want 0", bubble); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL mrst_pcwrite_in: got %b want 1", pc_write); end
      tick();
      reset_n = 1'b1;
      #1;
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL mrst_bubble: got %b want 0", bubble); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL mrst_pcwrite: got %b want 1", pc_write); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mrst_count: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_id(OPC_BEQ, 5'd5, 5'd0, 1'b0);
      set_ex(1'b1, 1'b0, 5'd5);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL sat_bubble%0d: got %b want 1", i, bubble); end
         tick();
      end
      set_ex(1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (c2_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_count2: got %0d want 3", c2_stall_cnt); end
      checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_count16: got %0d want 5", stall_cnt); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL sat_pcwrite: got %b want 1", pc_write); end
   endtask

   task automatic test_no_dep();
      do_reset();
      set_id(OPC_BEQ, 5'd5, 5'd6, 1'b0);
      set_ex(1'b1, 1'b0, 5'd7);
      set_mem(1'b1, 5'd8);
      #1;
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL nodep_bubble: got %b want 0", bubble); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL nodep_pcwrite: got %b want 1", pc_write); end
      set_id(OPC_ALU, 5'd5, 5'd6, 1'b1);
      set_ex(1'b1, 1'b1, 5'd5);
      set_mem(1'b0, 5'd0);
      #1;
      checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL nonbr_bubble: got %b want 0", bubble); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nonbr_flush: got %b want 0", flush); end
      tick();
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL nonbr_count: got %0d want 0", stall_cnt); end
   endtask

   initial begin
      reset_n = 1'b0;
      clear_all();
      test_reset();
      test_load_use();
      test_single_stall();
      test_rd_zero_flush();
      test_jalr();
      test_hold();
      test_reset_mid_stall();
      test_saturation();
      test_no_dep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
